// File: rtl/glb_ld_addr_gen_pkg.sv
// Shared global-buffer types: header layout, loop controls, mode and FSM encodings,
// width constants and small header helpers used by the load address generator.
package glb_ld_addr_gen_pkg;

  localparam int LOOP_LEVEL          = 4;
  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int MAX_RANGE_WIDTH     = 21;
  localparam int MAX_STRIDE_WIDTH    = 11;
  localparam int MAX_NUM_WORDS_WIDTH = 21;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_NORMAL    = 2'd1,
    MODE_REPEAT    = 2'd2,
    MODE_AUTO_INCR = 2'd3
  } glb_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_INACTIVE = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [MAX_RANGE_WIDTH-1:0]  range;
    logic [MAX_STRIDE_WIDTH-1:0] stride;
  } loop_ctrl_t;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    loop_ctrl_t [LOOP_LEVEL-1:0]    loop_ctrl;
  } dma_ld_header_t;

  // A programmed range of zero behaves like a single iteration.
  function automatic logic [MAX_RANGE_WIDTH-1:0] eff_range(input logic [MAX_RANGE_WIDTH-1:0] r);
    return (r == '0) ? MAX_RANGE_WIDTH'(1) : r;
  endfunction

  function automatic logic hdr_single_word(input dma_ld_header_t h);
    logic single;
    single = 1'b1;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      if (eff_range(h.loop_ctrl[i].range) != MAX_RANGE_WIDTH'(1)) single = 1'b0;
    end
    return single;
  endfunction

endpackage

// File: rtl/glb_ld_addr_gen_hdr_fifo.sv
// glb_hdr_fifo: small first-word-fall-through header queue; a push into a full
// queue is accepted only when a pop happens in the same cycle.
module glb_hdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/glb_ld_addr_gen.sv
// Global-buffer load address generator: queues DMA headers and walks a nested
// loop address pattern per header, with optional active/inactive duty cycling.
module glb_ld_addr_gen
  import glb_ld_addr_gen_pkg::*;
#(
  parameter int LOOP_LEVEL          = glb_ld_addr_gen_pkg::LOOP_LEVEL,
  parameter int QUEUE_DEPTH         = 4,
  parameter int GLB_ADDR_WIDTH      = glb_ld_addr_gen_pkg::GLB_ADDR_WIDTH,
  parameter int MAX_RANGE_WIDTH     = glb_ld_addr_gen_pkg::MAX_RANGE_WIDTH,
  parameter int MAX_STRIDE_WIDTH    = glb_ld_addr_gen_pkg::MAX_STRIDE_WIDTH,
  parameter int MAX_NUM_WORDS_WIDTH = glb_ld_addr_gen_pkg::MAX_NUM_WORDS_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                cfg_mode,
  input  logic                      hdr_wr_en,
  input  dma_ld_header_t            hdr_wr_data,
  output logic                      hdr_full,
  output logic                      hdr_ovf,
  input  logic                      strm_start,
  output logic                      rdrq_valid,
  input  logic                      rdrq_ready,
  output logic [GLB_ADDR_WIDTH-1:0] rdrq_addr,
  output logic                      rdrq_last,
  output logic                      strm_done,
  output logic                      busy
);
  localparam int AW = GLB_ADDR_WIDTH;
  localparam int RW = MAX_RANGE_WIDTH;
  localparam int NW = MAX_NUM_WORDS_WIDTH;

  glb_mode_e      mode;
  dma_ld_header_t fifo_head;
  logic           fifo_empty, fifo_pop;
  logic           unused_hdr_valid;

  ld_state_e      state_q;
  logic [AW-1:0]  start_q, addr_q;
  logic [NW-1:0]  act_words_q, inact_words_q, act_cnt_q, inact_cnt_q;
  logic [RW-1:0]  range_q [LOOP_LEVEL];
  logic [AW-1:0]  step_q  [LOOP_LEVEL];
  logic [RW-1:0]  itr_q   [LOOP_LEVEL];
  logic [AW-1:0]  acc_q   [LOOP_LEVEL];
  logic           last_q, done_q, ovf_q;

  logic [LOOP_LEVEL:0]   carry;
  logic [LOOP_LEVEL-1:0] at_end, end_d, unit_range;
  logic [RW-1:0]         itr_d    [LOOP_LEVEL];
  logic [AW-1:0]         acc_d    [LOOP_LEVEL];
  logic [AW-1:0]         addr_sum [LOOP_LEVEL+1];
  logic                  unused_carry, duty_en, rep_last;

  assign mode             = glb_mode_e'(cfg_mode);
  assign fifo_pop         = (state_q == ST_LOAD);
  assign unused_hdr_valid = fifo_head.valid;
  assign unused_carry     = carry[LOOP_LEVEL];

  glb_hdr_fifo #(
    .WIDTH($bits(dma_ld_header_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_hdr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (hdr_wr_en),
    .push_data_i(hdr_wr_data),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (hdr_full),
    .empty_o    (fifo_empty)
  );

  // Each level keeps itr*step in its own accumulator, so the address is a plain sum.
  assign carry[0]    = 1'b1;
  assign addr_sum[0] = start_q;
  generate
    for (genvar gi = 0; gi < LOOP_LEVEL; gi++) begin : g_level
      assign at_end[gi]       = (itr_q[gi] == range_q[gi] - 1'b1);
      assign carry[gi+1]      = carry[gi] & at_end[gi];
      assign itr_d[gi]        = !carry[gi] ? itr_q[gi] : (at_end[gi] ? '0 : itr_q[gi] + 1'b1);
      assign acc_d[gi]        = !carry[gi] ? acc_q[gi] : (at_end[gi] ? '0 : acc_q[gi] + step_q[gi]);
      assign end_d[gi]        = (itr_d[gi] == range_q[gi] - 1'b1);
      assign unit_range[gi]   = (range_q[gi] == RW'(1));
      assign addr_sum[gi+1]   = addr_sum[gi] + acc_d[gi];
    end
  endgenerate

  assign duty_en  = (act_words_q != '0) && (inact_words_q != '0);
  assign rep_last = &unit_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= '0;
      addr_q        <= '0;
      act_words_q   <= '0;
      inact_words_q <= '0;
      act_cnt_q     <= '0;
      inact_cnt_q   <= '0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        range_q[i] <= '0;
        step_q[i]  <= '0;
        itr_q[i]   <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (hdr_wr_en && hdr_full && !fifo_pop) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (strm_start && !fifo_empty && (mode != MODE_OFF)) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          start_q       <= fifo_head.start_addr;
          addr_q        <= fifo_head.start_addr;
          act_words_q   <= fifo_head.num_active_words;
          inact_words_q <= fifo_head.num_inactive_words;
          act_cnt_q     <= '0;
          inact_cnt_q   <= '0;
          last_q        <= hdr_single_word(fifo_head);
          for (int i = 0; i < LOOP_LEVEL; i++) begin
            range_q[i] <= eff_range(fifo_head.loop_ctrl[i].range);
            step_q[i]  <= AW'({fifo_head.loop_ctrl[i].stride[MAX_STRIDE_WIDTH-1:0], 1'b0});
            itr_q[i]   <= '0;
            acc_q[i]   <= '0;
          end
          state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (rdrq_ready) begin
            if (last_q) begin
              // Header complete: rewind so REPEAT can reissue without a reload.
              done_q    <= 1'b1;
              addr_q    <= start_q;
              act_cnt_q <= '0;
              last_q    <= rep_last;
              for (int i = 0; i < LOOP_LEVEL; i++) begin
                itr_q[i] <= '0;
                acc_q[i] <= '0;
              end
              case (mode)
                MODE_REPEAT:    state_q <= ST_ACTIVE;
                MODE_AUTO_INCR: state_q <= fifo_empty ? ST_IDLE : ST_LOAD;
                default:        state_q <= ST_IDLE;
              endcase
            end else begin
              addr_q <= addr_sum[LOOP_LEVEL];
              last_q <= &end_d;
              for (int i = 0; i < LOOP_LEVEL; i++) begin
                itr_q[i] <= itr_d[i];
                acc_q[i] <= acc_d[i];
              end
              if (duty_en) begin
                if (act_cnt_q == act_words_q - 1'b1) begin
                  act_cnt_q   <= '0;
                  inact_cnt_q <= '0;
                  state_q     <= ST_INACTIVE;
                end else begin
                  act_cnt_q <= act_cnt_q + 1'b1;
                end
              end
            end
          end
        end
        ST_INACTIVE: begin
          if (inact_cnt_q == inact_words_q - 1'b1) state_q <= ST_ACTIVE;
          else                                     inact_cnt_q <= inact_cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdrq_valid = (state_q == ST_ACTIVE);
  assign rdrq_addr  = addr_q;
  assign rdrq_last  = last_q && rdrq_valid;
  assign strm_done  = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign hdr_ovf    = ovf_q;

endmodule
